text_console_gen: RTL and testbench

TEXT_CONSOLE_GEN -- requirements
Module: text_console_gen

---
 rtl/text_console_pkg.sv | 29 ++
 rtl/fontrom.sv | 48 ++++
 rtl/text_tile_ram.sv | 33 +++
 rtl/text_console_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_text_console_gen.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_console_pkg.sv
// ----------------------------------------------------------------------------
// text_console_pkg: shared FSM type, cell geometry and control codes.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package text_console_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int CHAR_W_BITS = $clog2(CHAR_W);
  localparam int CHAR_H_BITS = $clog2(CHAR_H);

  localparam logic [6:0] CR    = 7'h0D;
  localparam logic [6:0] LF    = 7'h0A;
  localparam logic [6:0] BS    = 7'h08;
  localparam logic [6:0] SPACE = 7'h20;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fontrom.sv
// ----------------------------------------------------------------------------
// fontrom: 8x16 glyph ROM with registered output, addressed by {char, glyph row}.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fontrom
  import text_console_pkg::*;
(
  input  logic                   clk,
  input  logic [6:0]             i_char,
  input  logic [CHAR_H_BITS-1:0] i_row,
  output logic [CHAR_W-1:0]      o_bits
);

  logic [CHAR_W-1:0] w_bits;
  logic [CHAR_W-1:0] r_bits;

  // 'A' carries a real glyph; other printable codes show a hollow box, space and controls are blank.
  always_comb begin
    w_bits = '0;
    if (i_char == 7'h41) begin
      case (i_row)
        4'd2:                    w_bits = 8'h10;
        4'd3:                    w_bits = 8'h38;
        4'd4:                    w_bits = 8'h6C;
        4'd5, 4'd6:              w_bits = 8'hC6;
        4'd7:                    w_bits = 8'hFE;
        4'd8, 4'd9, 4'd10, 4'd11: w_bits = 8'hC6;
        default:                 w_bits = 8'h00;
      endcase
    end else if (i_char > SPACE && i_char < 7'h7F) begin
      if (i_row == 4'd2 || i_row == 4'd12) begin
        w_bits = 8'h7E;
      end else if (i_row > 4'd2 && i_row < 4'd12) begin
        w_bits = 8'h42;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_bits <= w_bits;
  end

  assign o_bits = r_bits;

endmodule

`default_nettype wire

// File: rtl/text_tile_ram.sv
// ----------------------------------------------------------------------------
// text_tile_ram: one-write/one-read character RAM, 1-cycle registered read.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module text_tile_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int DW    = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/text_console_gen.sv
// ----------------------------------------------------------------------------
// text_console_gen: character-cell text console with cursor and clear sweep.
// Optional: define CURSOR_BLINK_EN for a blinking cursor.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module text_console_gen
  import text_console_pkg::*;
#(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [23:0] FG_RGB     = 24'hFF1020,
  parameter logic [23:0] BG_RGB     = 24'h000000,
  parameter int          BLINK_BITS = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       wr_valid,
  input  logic [6:0] wr_char,
  output logic       wr_ready,
  input  logic       clr_req,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out
);

  localparam int            DEPTH     = COLS * ROWS;
  localparam int            AW        = addr_width(DEPTH);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);
  localparam logic [6:0]    LAST_PRN  = 7'h7E;

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_clr_addr, w_clr_addr_nx;
  logic [6:0]    r_cur_x, w_cur_x_nx;
  logic [4:0]    r_cur_y, w_cur_y_nx;
  logic [4:0]    w_row_inc;
  logic [AW-1:0] w_cur_addr;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [6:0]    w_wdata;

  assign wr_ready   = (r_state == ST_IDLE) && !clr_req;
  assign w_cur_addr = AW'(r_cur_y) * COLS_A + AW'(r_cur_x);
  assign w_row_inc  = (r_cur_y == LAST_ROW) ? 5'd0 : r_cur_y + 5'd1;

  always_comb begin
    w_state_nx    = r_state;
    w_clr_addr_nx = r_clr_addr;
    w_cur_x_nx    = r_cur_x;
    w_cur_y_nx    = r_cur_y;
    w_we          = 1'b0;
    w_waddr       = w_cur_addr;
    w_wdata       = SPACE;
    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nx    = ST_IDLE;
          w_clr_addr_nx = '0;
          w_cur_x_nx    = '0;
          w_cur_y_nx    = '0;
        end else begin
          w_clr_addr_nx = r_clr_addr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nx    = ST_CLEAR;
          w_clr_addr_nx = '0;
        end else if (wr_valid) begin
          if (wr_char >= SPACE && wr_char <= LAST_PRN) begin
            w_we    = 1'b1;
            w_wdata = wr_char;
            if (r_cur_x == LAST_COL) begin
              w_cur_x_nx = '0;
              w_cur_y_nx = w_row_inc;
            end else begin
              w_cur_x_nx = r_cur_x + 7'd1;
            end
          end else if (wr_char == CR) begin
            w_cur_x_nx = '0;
          end else if (wr_char == LF) begin
            w_cur_x_nx = '0;
            w_cur_y_nx = w_row_inc;
          end else if (wr_char == BS && r_cur_x != 7'd0) begin
            // Erase the cell the cursor steps back onto.
            w_cur_x_nx = r_cur_x - 7'd1;
            w_we       = 1'b1;
            w_waddr    = w_cur_addr - 1'b1;
          end
        end
      end
      default: w_state_nx = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_clr_addr <= w_clr_addr_nx;
      r_cur_x    <= w_cur_x_nx;
      r_cur_y    <= w_cur_y_nx;
    end
  end

  assign cur_x = r_cur_x;
  assign cur_y = r_cur_y;

  // Display path: stage 1 = tile RAM read, stage 2 = font ROM read.
  logic [9-CHAR_W_BITS:0]   w_col;
  logic [9-CHAR_H_BITS:0]   w_row;
  logic                     w_inside;
  logic [AW-1:0]            w_raddr;
  logic [6:0]               w_tile;
  logic [CHAR_W-1:0]        w_font;
  logic                     r_von1, r_in1, r_von2, r_in2;
  logic [6:0]               r_col1, r_col2;
  logic [4:0]               r_row1, r_row2;
  logic [CHAR_H_BITS-1:0]   r_gly1;
  logic [CHAR_W_BITS-1:0]   r_bit1, r_bit2;

  assign w_col    = pixel_x[9:CHAR_W_BITS];
  assign w_row    = pixel_y[9:CHAR_H_BITS];
  assign w_inside = (w_col <= LAST_COL) && (w_row <= {1'b0, LAST_ROW});
  assign w_raddr  = w_inside ? (AW'(w_row) * COLS_A + AW'(w_col)) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_von1 <= 1'b0;
      r_in1  <= 1'b0;
      r_col1 <= '0;
      r_row1 <= '0;
      r_gly1 <= '0;
      r_bit1 <= '0;
      r_von2 <= 1'b0;
      r_in2  <= 1'b0;
      r_col2 <= '0;
      r_row2 <= '0;
      r_bit2 <= '0;
    end else begin
      r_von1 <= video_on;
      r_in1  <= w_inside;
      r_col1 <= w_col;
      r_row1 <= w_row[4:0];
      r_gly1 <= pixel_y[CHAR_H_BITS-1:0];
      r_bit1 <= pixel_x[CHAR_W_BITS-1:0];
      r_von2 <= r_von1;
      r_in2  <= r_in1;
      r_col2 <= r_col1;
      r_row2 <= r_row1;
      r_bit2 <= r_bit1;
    end
  end

  text_tile_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (7)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_tile)
  );

  fontrom u_font (
    .clk    (clk),
    .i_char (w_tile),
    .i_row  (r_gly1),
    .o_bits (w_font)
  );

  logic w_cur_vis;

`ifdef CURSOR_BLINK_EN
  logic [BLINK_BITS-1:0] r_blink;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + 1'b1;
    end
  end

  assign w_cur_vis = ~r_blink[BLINK_BITS-1];
`else
  // Steady cursor; BLINK_BITS is only meaningful in the blinking build.
  assign w_cur_vis = (BLINK_BITS > 0) || 1'b1;
`endif

  logic        w_cursor_hit;
  logic        w_pix_fg;
  logic [23:0] w_rgb;

  assign w_cursor_hit = r_in2 && (r_col2 == r_cur_x) && (r_row2 == r_cur_y) && w_cur_vis;
  // Leftmost pixel of a cell is glyph bit 7.
  assign w_pix_fg     = w_font[~r_bit2] ^ w_cursor_hit;
  assign w_rgb        = !r_von2 ? 24'h000000 :
                        !r_in2  ? BG_RGB     :
                        w_pix_fg ? FG_RGB    : BG_RGB;

  assign red_out   = w_rgb[23:16];
  assign green_out = w_rgb[15:8];
  assign blue_out  = w_rgb[7:0];

endmodule

`default_nettype wire

// File: tb/tb_text_console_gen.sv
// ----------------------------------------------------------------------------
// tb_text_console_gen: directed self-checking bench for text_console_gen.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_text_console_gen;

  localparam logic [23:0] FG       = 24'hFF1020;
  localparam logic [23:0] BG       = 24'h0000A0;
  localparam int          TB_BLINK = 6;
  localparam int          NCELL    = 2400;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       video_on = 1'b1;
  logic [9:0] pixel_x = 10'd640;
  logic [9:0] pixel_y = 10'd0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_char = 7'd0;
  logic       wr_ready;
  logic       clr_req = 1'b0;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic [7:0] red_out, green_out, blue_out;

  int n_checks = 0;
  int n_fail   = 0;

  text_console_gen #(
    .COLS       (80),
    .ROWS       (30),
    .FG_RGB     (FG),
    .BG_RGB     (BG),
    .BLINK_BITS (TB_BLINK)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .wr_valid  (wr_valid),
    .wr_char   (wr_char),
    .wr_ready  (wr_ready),
    .clr_req   (clr_req),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .red_out   (red_out),
    .green_out (green_out),
    .blue_out  (blue_out)
  );

  always #5 clk = ~clk;

`ifdef CURSOR_BLINK_EN
  logic [TB_BLINK-1:0] tb_blink;
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_blink <= '0;
    else        tb_blink <= tb_blink + 1'b1;
  end
  function automatic logic tb_cur_vis();
    return ~tb_blink[TB_BLINK-1];
  endfunction
`else
  function automatic logic tb_cur_vis();
    return 1'b1;
  endfunction
`endif

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic        is_cur;
    logic [23:0] exp;
  } pix_vec_t;

  localparam int NV = 16;
  pix_vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cur();
    return {20'd0, cur_y, cur_x};
  endfunction

  function automatic logic [31:0] pk(input int x, input int y);
    return {20'd0, y[4:0], x[6:0]};
  endfunction

  function automatic logic [31:0] rgb();
    return {8'd0, red_out, green_out, blue_out};
  endfunction

  function automatic logic [31:0] ram_at(input int a);
    return {25'd0, u_dut.u_ram.r_mem[a]};
  endfunction

  // Expected colour for a vector, accounting for a hidden cursor phase.
  function automatic logic [31:0] eff_exp(input logic is_cur, input logic [23:0] exp);
    if (is_cur && !tb_cur_vis()) return {8'd0, (exp == FG) ? BG : FG};
    return {8'd0, exp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] ch);
    wr_valid = 1'b1;
    wr_char  = ch;
    chk("wr_ready_at_send", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic count_until_ready(output int n);
    n = 0;
    while (wr_ready !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic check_all_space(input string name);
    int bad = 0;
    for (int i = 0; i < NCELL; i++) begin
      if (ram_at(i) !== 32'h20) bad++;
    end
    chk(name, bad, 0);
  endtask

  task automatic check_pix(input string name, input int x, input int y,
                           input logic is_cur, input logic [23:0] exp);
    video_on = 1'b1;
    pixel_x  = x[9:0];
    pixel_y  = y[9:0];
    tick();
    tick();
    chk(name, rgb(), eff_exp(is_cur, exp));
  endtask

  initial begin
    int n;

    vecs[0]  = '{10'd8,    10'd0,   1'b1, 1'b0, BG};
    vecs[1]  = '{10'd11,   10'd2,   1'b1, 1'b0, FG};
    vecs[2]  = '{10'd10,   10'd2,   1'b1, 1'b0, BG};
    vecs[3]  = '{10'd8,    10'd5,   1'b1, 1'b0, FG};
    vecs[4]  = '{10'd15,   10'd7,   1'b1, 1'b0, BG};
    vecs[5]  = '{10'd14,   10'd7,   1'b1, 1'b0, FG};
    vecs[6]  = '{10'd11,   10'd2,   1'b0, 1'b0, 24'h000000};
    vecs[7]  = '{10'd640,  10'd0,   1'b1, 1'b0, BG};
    vecs[8]  = '{10'd8,    10'd480, 1'b1, 1'b0, BG};
    vecs[9]  = '{10'd0,    10'd64,  1'b1, 1'b1, FG};
    vecs[10] = '{10'd5,    10'd70,  1'b1, 1'b1, FG};
    vecs[11] = '{10'd16,   10'd0,   1'b1, 1'b0, BG};
    vecs[12] = '{10'd11,   10'd13,  1'b1, 1'b0, BG};
    vecs[13] = '{10'd9,    10'd10,  1'b1, 1'b0, FG};
    vecs[14] = '{10'd11,   10'd514, 1'b1, 1'b0, BG};
    vecs[15] = '{10'd1023, 10'd1023,1'b1, 1'b0, BG};

    // Reset state
    repeat (3) tick();
    chk("reset_rgb", rgb(), 32'd0);
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("reset_cursor", cur(), pk(0, 0));
    reset = 1'b1;
    count_until_ready(n);
    chk("init_clear_cycles", n, NCELL);
    chk("init_cursor", cur(), pk(0, 0));
    check_all_space("init_all_space");

    // Last cell write and full wrap
    repeat (29) send(LF_CODE());
    chk("lf_to_row29", cur(), pk(0, 29));
    repeat (79) send(7'h42);
    chk("cursor_79_29", cur(), pk(79, 29));
    send(7'h41);
    chk("ram_2399_A", ram_at(2399), 32'h41);
    chk("ram_2398_B", ram_at(2398), 32'h42);
    chk("wrap_cursor", cur(), pk(0, 0));

    // Clear request beats a simultaneous write; clr_req mid-sweep ignored
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_char  = 7'h5A;
    #1;
    chk("wr_ready_with_clr", {31'd0, wr_ready}, 32'd0);
    tick();
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    chk("clr_char_not_accepted", cur(), pk(0, 0));
    repeat (20) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    count_until_ready(n);
    chk("clr_sweep_cycles", 22 + n, NCELL + 1);
    chk("clr_cursor", cur(), pk(0, 0));
    check_all_space("clr_all_space");

    // Backspace
    send(7'h48);
    send(7'h49);
    send(7'h08);
    chk("bs_cursor", cur(), pk(1, 0));
    chk("bs_ram1_space", ram_at(1), 32'h20);
    chk("bs_ram0_H", ram_at(0), 32'h48);
    send(7'h41);
    chk("ram1_A", ram_at(1), 32'h41);
    send(7'h0D);
    send(7'h08);
    chk("bs_at_col0_cursor", cur(), pk(0, 0));
    chk("bs_at_col0_ram0", ram_at(0), 32'h48);

    // LF / CR / ignored codes
    repeat (3) send(7'h0A);
    repeat (5) send(7'h78);
    chk("cursor_5_3", cur(), pk(5, 3));
    send(7'h0A);
    chk("lf_cursor", cur(), pk(0, 4));
    send(7'h0D);
    chk("cr_cursor", cur(), pk(0, 4));
    chk("lf_no_write", ram_at(245), 32'h20);
    chk("cr_no_write", ram_at(320), 32'h20);
    send(7'h01);
    send(7'h7F);
    chk("ignored_cursor", cur(), pk(0, 4));
    chk("ignored_no_write", ram_at(320), 32'h20);

    // Display table, one vector per cycle, result 2 cycles later
    for (int k = 0; k <= NV; k++) begin
      if (k < NV) begin
        pixel_x  = vecs[k].x;
        pixel_y  = vecs[k].y;
        video_on = vecs[k].von;
      end
      tick();
      if (k >= 1) begin
        chk($sformatf("pix_vec%0d", k - 1), rgb(), eff_exp(vecs[k-1].is_cur, vecs[k-1].exp));
      end
    end

    // Cursor over a glyph
    repeat (26) send(7'h0A);
    chk("lf_row_wrap", cur(), pk(0, 0));
    send(7'h48);
    check_pix("cursor_on_A_set", 11, 2, 1'b1, BG);
    check_pix("cursor_on_A_clr", 10, 2, 1'b1, FG);

    // Reset during a clear sweep restarts it
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    pixel_x = 10'd640;
    pixel_y = 10'd0;
    repeat (100) tick();
    chk("pre_reset_rgb", rgb(), {8'd0, BG});
    chk("pre_reset_cursor", cur(), pk(1, 0));
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_cursor", cur(), pk(0, 0));
    chk("async_reset_rgb", rgb(), 32'd0);
    tick();
    reset = 1'b1;
    count_until_ready(n);
    chk("restart_clear_cycles", n, NCELL);
    check_all_space("restart_all_space");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [6:0] LF_CODE();
    return 7'h0A;
  endfunction

endmodule

`default_nettype wire
